// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display arbiter.
// Segment octets use bit index = segment index: bit 0 = a ... bit 6 = g, bit 7 = dp.
// Font entries are written in a..dp reading order and converted with seg_ad().
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Convert an octet written left-to-right as a,b,c,d,e,f,g,dp into bit-indexed form.
  function automatic logic [7:0] seg_ad(input logic [7:0] s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = s[7-i];
    return r;
  endfunction

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DASH  = seg_ad(8'b00000010);

  localparam logic [7:0] HEX_FONT [16] = '{
    seg_ad(8'b11111100), seg_ad(8'b01100000), seg_ad(8'b11011010), seg_ad(8'b11110010),
    seg_ad(8'b01100110), seg_ad(8'b10110110), seg_ad(8'b10111110), seg_ad(8'b11100000),
    seg_ad(8'b11111110), seg_ad(8'b11110110), seg_ad(8'b11101110), seg_ad(8'b00111110),
    seg_ad(8'b10011100), seg_ad(8'b01111010), seg_ad(8'b10011110), seg_ad(8'b10001110)
  };

endpackage

// File: rtl/seg_display_arbiter_hex_to_seg.sv
// Combinational hex digit encoder.
// Ports: nib (hex digit), dp (decimal point), seg_c (segment octet, bit index = segment index).
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg_c
);

  always_comb begin
    seg_c         = HEX_FONT[nib];
    seg_c[SEG_DP] = dp;
  end

endmodule

// File: rtl/seg_display_arbiter.sv
// Two-requester round-robin arbiter for a shared 4-digit seven-segment display,
// with minimum ownership time and hex encoding of the owner's value.
// Ports:
//   Clock, Reset      - rising-edge clock, synchronous active-high reset
//   Req[1:0]          - hold-style requests
//   Val0/Val1, Dp0/Dp1- per-requester 16-bit hex value and decimal points ([3]/[15:12] leftmost)
//   Gnt[1:0], Busy    - registered one-hot grant and "any grant held"
//   oct0..oct3        - registered segment octets, oct0 leftmost, bit index = segment (a=0..dp=7)
// Optional: define DISP_IDLE_BLINK_EN to blink a dash on all digits while idle.
module seg_display_arbiter
  import seg_pkg::*;
#(
  parameter int unsigned HOLD = 50000000,
  parameter int unsigned CW   = 26
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [1:0]  Req,
  input  logic [15:0] Val0,
  input  logic [15:0] Val1,
  input  logic [3:0]  Dp0,
  input  logic [3:0]  Dp1,
  output logic [1:0]  Gnt,
  output logic        Busy,
  output logic [7:0]  oct0,
  output logic [7:0]  oct1,
  output logic [7:0]  oct2,
  output logic [7:0]  oct3
);

  state_t        state;
  state_t        nxt_c;
  logic [CW-1:0] cnt;
  logic          last_own;
  logic          at_hold_c;
  logic [7:0]    idle_oct_c;
  logic [15:0]   sel_val_c;
  logic [3:0]    sel_dp_c;
  logic [7:0]    enc_c [4];

`ifdef DISP_IDLE_BLINK_EN
  logic          blink;
  assign idle_oct_c = blink ? SEG_DASH : SEG_BLANK;
`else
  assign idle_oct_c = SEG_BLANK;
`endif

  assign at_hold_c = (cnt == CW'(HOLD - 1));

  // Owner's live data; in IDLE the encoder output is unused.
  assign sel_val_c = (state == OWN1) ? Val1 : Val0;
  assign sel_dp_c  = (state == OWN1) ? Dp1  : Dp0;

  for (genvar k = 0; k < 4; k++) begin : g_enc
    hex_to_seg u_hex (
      .nib   (sel_val_c[15-4*k -: 4]),
      .dp    (sel_dp_c[3-k]),
      .seg_c (enc_c[k])
    );
  end

  // Next-owner decision: voluntary release ignores hold, preemption needs full hold.
  always_comb begin
    nxt_c = state;
    case (state)
      IDLE: begin
        case (Req)
          2'b01:   nxt_c = OWN0;
          2'b10:   nxt_c = OWN1;
          2'b11:   nxt_c = last_own ? OWN0 : OWN1;
          default: nxt_c = IDLE;
        endcase
      end
      OWN0: begin
        if (!Req[0])                nxt_c = Req[1] ? OWN1 : IDLE;
        else if (Req[1] && at_hold_c) nxt_c = OWN1;
      end
      OWN1: begin
        if (!Req[1])                nxt_c = Req[0] ? OWN0 : IDLE;
        else if (Req[0] && at_hold_c) nxt_c = OWN0;
      end
      default: nxt_c = IDLE;
    endcase
  end

  // State, grant, hold counter, owner pointer and octet registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      Gnt      <= 2'b00;
      Busy     <= 1'b0;
      cnt      <= '0;
      last_own <= 1'b1;
      oct0     <= 8'h00;
      oct1     <= 8'h00;
      oct2     <= 8'h00;
      oct3     <= 8'h00;
`ifdef DISP_IDLE_BLINK_EN
      blink    <= 1'b0;
`endif
    end else begin
      state <= nxt_c;
      Gnt   <= (nxt_c == OWN0) ? 2'b01 : (nxt_c == OWN1) ? 2'b10 : 2'b00;
      Busy  <= (nxt_c != IDLE);

      if (nxt_c != state) begin
        cnt <= '0;
        if (nxt_c == OWN0) last_own <= 1'b0;
        if (nxt_c == OWN1) last_own <= 1'b1;
`ifdef DISP_IDLE_BLINK_EN
        if (nxt_c == IDLE) blink <= 1'b0;
`endif
      end else if (state != IDLE) begin
        if (!at_hold_c) cnt <= cnt + CW'(1);
      end else begin
`ifdef DISP_IDLE_BLINK_EN
        // Free-running idle counter; each wrap flips the dash.
        if (at_hold_c) begin
          cnt   <= '0;
          blink <= ~blink;
        end else begin
          cnt <= cnt + CW'(1);
        end
`else
        cnt <= '0;
`endif
      end

      if (state == IDLE) begin
        oct0 <= idle_oct_c;
        oct1 <= idle_oct_c;
        oct2 <= idle_oct_c;
        oct3 <= idle_oct_c;
      end else begin
        oct0 <= enc_c[0];
        oct1 <= enc_c[1];
        oct2 <= enc_c[2];
        oct3 <= enc_c[3];
      end
    end
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized self-checking bench for seg_display_arbiter (HOLD=4), against a
// cycle-level model of the ownership rules and hex font.
module tb_seg_display_arbiter;

  localparam int HOLD = 4;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [1:0]  Req;
  logic [15:0] Val0, Val1;
  logic [3:0]  Dp0, Dp1;
  logic [1:0]  Gnt;
  logic        Busy;
  logic [7:0]  oct0, oct1, oct2, oct3;

  always #5 Clock = ~Clock;

  seg_display_arbiter #(.HOLD(HOLD), .CW(3)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req),
    .Val0(Val0), .Val1(Val1), .Dp0(Dp0), .Dp1(Dp1),
    .Gnt(Gnt), .Busy(Busy),
    .oct0(oct0), .oct1(oct1), .oct2(oct2), .oct3(oct3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Font in a..dp reading order, as listed for the display.
  logic [7:0] font_ad [16] = '{
    8'b11111100, 8'b01100000, 8'b11011010, 8'b11110010,
    8'b01100110, 8'b10110110, 8'b10111110, 8'b11100000,
    8'b11111110, 8'b11110110, 8'b11101110, 8'b00111110,
    8'b10011100, 8'b01111010, 8'b10011110, 8'b10001110
  };

  function automatic logic [7:0] to_bits(input logic [7:0] s);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = s[7-i];
    return r;
  endfunction

  // Model: owner -1 = none, 0/1 = requester; held = cycles spent by current owner.
  int         m_own = -1;
  int         m_held = 0;
  int         m_last = 1;
  bit         m_blink = 0;
  logic [7:0] e_oct [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic [1:0] e_gnt = 2'b00;

  task automatic model_step();
    int nxt;
    logic [15:0] v;
    logic [3:0]  d;
    logic [3:0]  nib;
    if (Reset) begin
      m_own = -1; m_held = 0; m_last = 1; m_blink = 0;
      for (int k = 0; k < 4; k++) e_oct[k] = 8'h00;
    end else begin
      v = (m_own == 1) ? Val1 : Val0;
      d = (m_own == 1) ? Dp1 : Dp0;
      for (int k = 0; k < 4; k++) begin
        if (m_own < 0) begin
          e_oct[k] = m_blink ? to_bits(8'b00000010) : 8'h00;
        end else begin
          nib = 4'((v >> (12 - 4*k)) & 16'hF);
          e_oct[k] = to_bits(font_ad[nib] | {7'd0, d[3-k]});
        end
      end
      nxt = m_own;
      if (m_own < 0) begin
        if (Req == 2'b01) nxt = 0;
        else if (Req == 2'b10) nxt = 1;
        else if (Req == 2'b11) nxt = 1 - m_last;
      end else if (!Req[m_own]) begin
        nxt = Req[1-m_own] ? 1 - m_own : -1;
      end else if (Req[1-m_own] && m_held == HOLD - 1) begin
        nxt = 1 - m_own;
      end
      if (nxt != m_own) begin
        m_held = 0;
        if (nxt >= 0) m_last = nxt;
        else m_blink = 0;
      end else if (m_own >= 0) begin
        if (m_held < HOLD - 1) m_held++;
      end else begin
`ifdef DISP_IDLE_BLINK_EN
        if (m_held == HOLD - 1) begin
          m_held = 0;
          m_blink = ~m_blink;
        end else begin
          m_held++;
        end
`endif
      end
      m_own = nxt;
    end
    e_gnt = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
  endtask

  task automatic compare_all();
    check("gnt", 16'(Gnt), 16'(e_gnt));
    check("busy", 16'(Busy), 16'(e_gnt != 2'b00));
    check("gnt_onehot", 16'(Gnt == 2'b11), 16'd0);
    check("oct0", 16'(oct0), 16'(e_oct[0]));
    check("oct1", 16'(oct1), 16'(e_oct[1]));
    check("oct2", 16'(oct2), 16'(e_oct[2]));
    check("oct3", 16'(oct3), 16'(e_oct[3]));
  endtask

  task automatic step(input logic r, input logic [1:0] q);
    Reset = r;
    Req   = q;
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    compare_all();
  endtask

  initial begin
    Reset = 1'b1; Req = 2'b11;
    Val0 = 16'h0000; Val1 = 16'h0000; Dp0 = 4'h0; Dp1 = 4'h0;

    // Reset with both requesting, then requester 0 wins the first tie.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b11);
      check("rst_gnt", 16'(Gnt), 16'd0);
      check("rst_oct0", 16'(oct0), 16'd0);
    end
    step(1'b0, 2'b11);
    check("first_tie", 16'(Gnt), 16'h0001);

    // Single requester 0 with a known value.
    step(1'b1, 2'b00);
    Val0 = 16'h12AF; Dp0 = 4'b0001;
    step(1'b0, 2'b01);
    check("own0_gnt", 16'(Gnt), 16'h0001);
    step(1'b0, 2'b01);
    check("lit_oct0", 16'(oct0), 16'(to_bits(8'b01100000)));
    check("lit_oct1", 16'(oct1), 16'(to_bits(8'b11011010)));
    check("lit_oct2", 16'(oct2), 16'(to_bits(8'b11101110)));
    check("lit_oct3", 16'(oct3), 16'(to_bits(8'b10001111)));

    // Contention: preemption after full hold, and back again.
    for (int i = 0; i < 12; i++) step(1'b0, 2'b11);
    // Voluntary release by the current owner, then idle blank/blink.
    step(1'b0, 2'b10);
    step(1'b0, 2'b01);
    step(1'b0, 2'b00);
    for (int i = 0; i < 12; i++) step(1'b0, 2'b00);
    // Mid-ownership reset.
    step(1'b0, 2'b10);
    step(1'b0, 2'b10);
    step(1'b1, 2'b10);
    step(1'b0, 2'b10);
    step(1'b0, 2'b10);

    // Random traffic with sticky requests and live data.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] q;
      logic       r;
      q = Req;
      if ($urandom_range(0, 5) == 0) q = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 199) == 0);
      Val0 = 16'($urandom); Val1 = 16'($urandom);
      Dp0 = 4'($urandom); Dp1 = 4'($urandom);
      step(r, q);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
